// File: rtl/e203_lsu_icb_arbt_pkg.sv
// Shared definitions for the LSU ICB arbiter: grant FSM states and
// requester source encodings stored in the outstanding-source FIFO.
package e203_lsu_icb_arbt_pkg;

  typedef enum logic [1:0] {
    ARBT_IDLE      = 2'd0,
    ARBT_LOCK_AGU  = 2'd1,
    ARBT_LOCK_NICE = 2'd2
  } arbt_state_e;

  typedef enum logic {
    SRC_AGU  = 1'b0,
    SRC_NICE = 1'b1
  } arbt_src_e;

  // A depth-1 FIFO still needs a 1-bit pointer to keep the ports legal.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/e203_lsu_arbt_srcfifo.sv
// In-order 1-bit FIFO remembering which requester owns each outstanding
// command. No bypass: a full FIFO refuses a push even when popped.
module e203_lsu_arbt_srcfifo
  import e203_lsu_icb_arbt_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned PW = ptr_width(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic          din_i,
  input  logic          pop_i,
  output logic          dout_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [DEPTH-1:0] mem_q;
  logic [PW-1:0]    wptr_q;
  logic [PW-1:0]    rptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign dout_o  = mem_q[rptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q  <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wptr_q] <= din_i;
        wptr_q        <= ptr_inc(wptr_q);
      end
      if (do_pop) begin
        rptr_q <= ptr_inc(rptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/e203_lsu_icb_arbt.sv
// Merges AGU and NICE ICB command streams onto the LSU port (NICE wins ties,
// grant locks until handshake) and routes responses back in issue order.
module e203_lsu_icb_arbt
  import e203_lsu_icb_arbt_pkg::*;
#(
  parameter int unsigned OUTS_DEPTH = 2,
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            nice_mem_holdup,

  input  logic            agu_icb_cmd_valid,
  output logic            agu_icb_cmd_ready,
  input  logic [AW-1:0]   agu_icb_cmd_addr,
  input  logic            agu_icb_cmd_read,
  input  logic [DW-1:0]   agu_icb_cmd_wdata,
  input  logic [DW/8-1:0] agu_icb_cmd_wmask,
  input  logic [1:0]      agu_icb_cmd_size,
  output logic            agu_icb_rsp_valid,
  input  logic            agu_icb_rsp_ready,
  output logic            agu_icb_rsp_err,
  output logic [DW-1:0]   agu_icb_rsp_rdata,

  input  logic            nice_icb_cmd_valid,
  output logic            nice_icb_cmd_ready,
  input  logic [AW-1:0]   nice_icb_cmd_addr,
  input  logic            nice_icb_cmd_read,
  input  logic [DW-1:0]   nice_icb_cmd_wdata,
  input  logic [DW/8-1:0] nice_icb_cmd_wmask,
  input  logic [1:0]      nice_icb_cmd_size,
  output logic            nice_icb_rsp_valid,
  input  logic            nice_icb_rsp_ready,
  output logic            nice_icb_rsp_err,
  output logic [DW-1:0]   nice_icb_rsp_rdata,

  output logic            lsu_icb_cmd_valid,
  input  logic            lsu_icb_cmd_ready,
  output logic [AW-1:0]   lsu_icb_cmd_addr,
  output logic            lsu_icb_cmd_read,
  output logic [DW-1:0]   lsu_icb_cmd_wdata,
  output logic [DW/8-1:0] lsu_icb_cmd_wmask,
  output logic [1:0]      lsu_icb_cmd_size,
  input  logic            lsu_icb_rsp_valid,
  output logic            lsu_icb_rsp_ready,
  input  logic            lsu_icb_rsp_err,
  input  logic [DW-1:0]   lsu_icb_rsp_rdata,

  output logic            arbt_active,
  output logic            rsp_orphan_err
);

  localparam int unsigned CW = $clog2(OUTS_DEPTH + 1);

  arbt_state_e   state_q, state_d;
  logic          grant_agu, grant_nice;
  logic          req_valid, cmd_hs, rsp_hs;
  logic          fifo_full, fifo_empty, fifo_head, head_nice;
  logic [CW-1:0] outs_cnt;
  logic          orphan_q;

  // Grant selection and lock tracking; reset forces the AGU path with no grant.
  always_comb begin
    grant_agu  = 1'b0;
    grant_nice = 1'b0;
    state_d    = state_q;
    case (state_q)
      ARBT_IDLE: begin
        grant_nice = nice_icb_cmd_valid;
        grant_agu  = agu_icb_cmd_valid & ~nice_mem_holdup & ~nice_icb_cmd_valid;
      end
      ARBT_LOCK_AGU:  grant_agu  = 1'b1;
      ARBT_LOCK_NICE: grant_nice = 1'b1;
      default: ;
    endcase
    if (rst) begin
      grant_agu  = 1'b0;
      grant_nice = 1'b0;
    end
    req_valid         = (grant_agu & agu_icb_cmd_valid) | (grant_nice & nice_icb_cmd_valid);
    lsu_icb_cmd_valid = req_valid & ~fifo_full;
    cmd_hs            = lsu_icb_cmd_valid & lsu_icb_cmd_ready;
    case (state_q)
      ARBT_IDLE: begin
        if (lsu_icb_cmd_valid && !lsu_icb_cmd_ready) begin
          state_d = grant_nice ? ARBT_LOCK_NICE : ARBT_LOCK_AGU;
        end
      end
      ARBT_LOCK_AGU, ARBT_LOCK_NICE: begin
        if (cmd_hs) state_d = ARBT_IDLE;
      end
      default: state_d = ARBT_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ARBT_IDLE;
    else     state_q <= state_d;
  end

  assign lsu_icb_cmd_addr  = grant_nice ? nice_icb_cmd_addr  : agu_icb_cmd_addr;
  assign lsu_icb_cmd_read  = grant_nice ? nice_icb_cmd_read  : agu_icb_cmd_read;
  assign lsu_icb_cmd_wdata = grant_nice ? nice_icb_cmd_wdata : agu_icb_cmd_wdata;
  assign lsu_icb_cmd_wmask = grant_nice ? nice_icb_cmd_wmask : agu_icb_cmd_wmask;
  assign lsu_icb_cmd_size  = grant_nice ? nice_icb_cmd_size  : agu_icb_cmd_size;

  assign agu_icb_cmd_ready  = grant_agu  & lsu_icb_cmd_ready & ~fifo_full;
  assign nice_icb_cmd_ready = grant_nice & lsu_icb_cmd_ready & ~fifo_full;

  e203_lsu_arbt_srcfifo #(.DEPTH(OUTS_DEPTH)) u_srcfifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (cmd_hs),
    .din_i   (grant_nice ? SRC_NICE : SRC_AGU),
    .pop_i   (rsp_hs),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (outs_cnt)
  );

  // Responses with nothing outstanding are drained and flagged, never routed.
  assign head_nice          = (arbt_src_e'(fifo_head) == SRC_NICE);
  assign agu_icb_rsp_valid  = ~rst & lsu_icb_rsp_valid & ~fifo_empty & ~head_nice;
  assign nice_icb_rsp_valid = ~rst & lsu_icb_rsp_valid & ~fifo_empty &  head_nice;
  assign lsu_icb_rsp_ready  = ~rst & (fifo_empty | (head_nice ? nice_icb_rsp_ready : agu_icb_rsp_ready));
  assign rsp_hs             = lsu_icb_rsp_valid & lsu_icb_rsp_ready & ~fifo_empty;

  assign agu_icb_rsp_err    = lsu_icb_rsp_err;
  assign agu_icb_rsp_rdata  = lsu_icb_rsp_rdata;
  assign nice_icb_rsp_err   = lsu_icb_rsp_err;
  assign nice_icb_rsp_rdata = lsu_icb_rsp_rdata;

  assign arbt_active = ~rst & (agu_icb_cmd_valid | nice_icb_cmd_valid | (outs_cnt != '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                  orphan_q <= 1'b0;
    else if (lsu_icb_rsp_valid && fifo_empty) orphan_q <= 1'b1;
  end

  assign rsp_orphan_err = orphan_q;

endmodule

// File: tb/tb_e203_lsu_icb_arbt.sv
// Scenario bench for the LSU ICB arbiter: directed grant/lock/full/orphan/reset
// cases followed by random traffic checked against a queue-based model.
module tb_e203_lsu_icb_arbt;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 2;

  logic clk, rst, nice_mem_holdup;
  logic agu_icb_cmd_valid, agu_icb_cmd_ready, agu_icb_cmd_read;
  logic [AW-1:0] agu_icb_cmd_addr;
  logic [DW-1:0] agu_icb_cmd_wdata;
  logic [DW/8-1:0] agu_icb_cmd_wmask;
  logic [1:0] agu_icb_cmd_size;
  logic agu_icb_rsp_valid, agu_icb_rsp_ready, agu_icb_rsp_err;
  logic [DW-1:0] agu_icb_rsp_rdata;
  logic nice_icb_cmd_valid, nice_icb_cmd_ready, nice_icb_cmd_read;
  logic [AW-1:0] nice_icb_cmd_addr;
  logic [DW-1:0] nice_icb_cmd_wdata;
  logic [DW/8-1:0] nice_icb_cmd_wmask;
  logic [1:0] nice_icb_cmd_size;
  logic nice_icb_rsp_valid, nice_icb_rsp_ready, nice_icb_rsp_err;
  logic [DW-1:0] nice_icb_rsp_rdata;
  logic lsu_icb_cmd_valid, lsu_icb_cmd_ready, lsu_icb_cmd_read;
  logic [AW-1:0] lsu_icb_cmd_addr;
  logic [DW-1:0] lsu_icb_cmd_wdata;
  logic [DW/8-1:0] lsu_icb_cmd_wmask;
  logic [1:0] lsu_icb_cmd_size;
  logic lsu_icb_rsp_valid, lsu_icb_rsp_ready, lsu_icb_rsp_err;
  logic [DW-1:0] lsu_icb_rsp_rdata;
  logic arbt_active, rsp_orphan_err;

  int chk_cnt = 0;
  int pass_cnt = 0;

  e203_lsu_icb_arbt #(.OUTS_DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .nice_mem_holdup(nice_mem_holdup),
    .agu_icb_cmd_valid(agu_icb_cmd_valid), .agu_icb_cmd_ready(agu_icb_cmd_ready),
    .agu_icb_cmd_addr(agu_icb_cmd_addr), .agu_icb_cmd_read(agu_icb_cmd_read),
    .agu_icb_cmd_wdata(agu_icb_cmd_wdata), .agu_icb_cmd_wmask(agu_icb_cmd_wmask),
    .agu_icb_cmd_size(agu_icb_cmd_size),
    .agu_icb_rsp_valid(agu_icb_rsp_valid), .agu_icb_rsp_ready(agu_icb_rsp_ready),
    .agu_icb_rsp_err(agu_icb_rsp_err), .agu_icb_rsp_rdata(agu_icb_rsp_rdata),
    .nice_icb_cmd_valid(nice_icb_cmd_valid), .nice_icb_cmd_ready(nice_icb_cmd_ready),
    .nice_icb_cmd_addr(nice_icb_cmd_addr), .nice_icb_cmd_read(nice_icb_cmd_read),
    .nice_icb_cmd_wdata(nice_icb_cmd_wdata), .nice_icb_cmd_wmask(nice_icb_cmd_wmask),
    .nice_icb_cmd_size(nice_icb_cmd_size),
    .nice_icb_rsp_valid(nice_icb_rsp_valid), .nice_icb_rsp_ready(nice_icb_rsp_ready),
    .nice_icb_rsp_err(nice_icb_rsp_err), .nice_icb_rsp_rdata(nice_icb_rsp_rdata),
    .lsu_icb_cmd_valid(lsu_icb_cmd_valid), .lsu_icb_cmd_ready(lsu_icb_cmd_ready),
    .lsu_icb_cmd_addr(lsu_icb_cmd_addr), .lsu_icb_cmd_read(lsu_icb_cmd_read),
    .lsu_icb_cmd_wdata(lsu_icb_cmd_wdata), .lsu_icb_cmd_wmask(lsu_icb_cmd_wmask),
    .lsu_icb_cmd_size(lsu_icb_cmd_size),
    .lsu_icb_rsp_valid(lsu_icb_rsp_valid), .lsu_icb_rsp_ready(lsu_icb_rsp_ready),
    .lsu_icb_rsp_err(lsu_icb_rsp_err), .lsu_icb_rsp_rdata(lsu_icb_rsp_rdata),
    .arbt_active(arbt_active), .rsp_orphan_err(rsp_orphan_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    nice_mem_holdup    = 1'b0;
    agu_icb_cmd_valid  = 1'b0;
    nice_icb_cmd_valid = 1'b0;
    lsu_icb_cmd_ready  = 1'b0;
    lsu_icb_rsp_valid  = 1'b0;
    agu_icb_rsp_ready  = 1'b0;
    nice_icb_rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive_idle();
    agu_icb_cmd_addr = '0; agu_icb_cmd_read = 1'b0; agu_icb_cmd_wdata = '0; agu_icb_cmd_wmask = '0; agu_icb_cmd_size = '0;
    nice_icb_cmd_addr = '0; nice_icb_cmd_read = 1'b0; nice_icb_cmd_wdata = '0; nice_icb_cmd_wmask = '0; nice_icb_cmd_size = '0;
    lsu_icb_rsp_err = 1'b0; lsu_icb_rsp_rdata = '0;
    agu_icb_cmd_valid = 1'b1; nice_icb_cmd_valid = 1'b1; lsu_icb_cmd_ready = 1'b1;
    lsu_icb_rsp_valid = 1'b1; agu_icb_rsp_ready = 1'b1; nice_icb_rsp_ready = 1'b1;
    #3;
    chk_cnt++; if ({agu_icb_cmd_ready, nice_icb_cmd_ready, lsu_icb_cmd_valid} !== 3'b000) $display("[TB] FAIL reset_cmd_hs: got %b expected 000", {agu_icb_cmd_ready, nice_icb_cmd_ready, lsu_icb_cmd_valid}); else pass_cnt++;
    chk_cnt++; if ({lsu_icb_rsp_ready, agu_icb_rsp_valid, nice_icb_rsp_valid} !== 3'b000) $display("[TB] FAIL reset_rsp_hs: got %b expected 000", {lsu_icb_rsp_ready, agu_icb_rsp_valid, nice_icb_rsp_valid}); else pass_cnt++;
    chk_cnt++; if ({arbt_active, rsp_orphan_err} !== 2'b00) $display("[TB] FAIL reset_status: got %b expected 00", {arbt_active, rsp_orphan_err}); else pass_cnt++;
    tick();
    rst = 1'b0;
    drive_idle();
  endtask

  task automatic test_priority();
    tick();
    agu_icb_cmd_valid = 1'b1; nice_icb_cmd_valid = 1'b1; lsu_icb_cmd_ready = 1'b1;
    agu_icb_cmd_addr = 32'hA000_0010; nice_icb_cmd_addr = 32'hB000_0020;
    #2;
    chk_cnt++; if ({nice_icb_cmd_ready, agu_icb_cmd_ready} !== 2'b10) $display("[TB] FAIL prio_c0_ready: got %b expected 10", {nice_icb_cmd_ready, agu_icb_cmd_ready}); else pass_cnt++;
    chk_cnt++; if (lsu_icb_cmd_addr !== 32'hB000_0020) $display("[TB] FAIL prio_c0_addr: got %h expected b0000020", lsu_icb_cmd_addr); else pass_cnt++;
    tick();
    nice_icb_cmd_valid = 1'b0;
    #2;
    chk_cnt++; if ({nice_icb_cmd_ready, agu_icb_cmd_ready, lsu_icb_cmd_valid} !== 3'b011) $display("[TB] FAIL prio_c1_ready: got %b expected 011", {nice_icb_cmd_ready, agu_icb_cmd_ready, lsu_icb_cmd_valid}); else pass_cnt++;
    chk_cnt++; if (lsu_icb_cmd_addr !== 32'hA000_0010) $display("[TB] FAIL prio_c1_addr: got %h expected a0000010", lsu_icb_cmd_addr); else pass_cnt++;
    tick();
    agu_icb_cmd_valid = 1'b0; lsu_icb_cmd_ready = 1'b0;
    lsu_icb_rsp_valid = 1'b1; lsu_icb_rsp_rdata = 32'h1111_2222; agu_icb_rsp_ready = 1'b1; nice_icb_rsp_ready = 1'b1;
    #2;
    chk_cnt++; if ({nice_icb_rsp_valid, agu_icb_rsp_valid} !== 2'b10) $display("[TB] FAIL prio_rsp0_route: got %b expected 10", {nice_icb_rsp_valid, agu_icb_rsp_valid}); else pass_cnt++;
    chk_cnt++; if (nice_icb_rsp_rdata !== 32'h1111_2222) $display("[TB] FAIL prio_rsp0_data: got %h expected 11112222", nice_icb_rsp_rdata); else pass_cnt++;
    tick();
    lsu_icb_rsp_rdata = 32'h3333_4444;
    #2;
    chk_cnt++; if ({nice_icb_rsp_valid, agu_icb_rsp_valid} !== 2'b01) $display("[TB] FAIL prio_rsp1_route: got %b expected 01", {nice_icb_rsp_valid, agu_icb_rsp_valid}); else pass_cnt++;
    chk_cnt++; if (agu_icb_rsp_rdata !== 32'h3333_4444) $display("[TB] FAIL prio_rsp1_data: got %h expected 33334444", agu_icb_rsp_rdata); else pass_cnt++;
    tick();
    drive_idle();
    #2;
    chk_cnt++; if (arbt_active !== 1'b0) $display("[TB] FAIL prio_drained: got %b expected 0", arbt_active); else pass_cnt++;
  endtask

  task automatic test_lock();
    tick();
    agu_icb_cmd_valid = 1'b1; agu_icb_cmd_addr = 32'h0000_0A10; lsu_icb_cmd_ready = 1'b0;
    #2;
    chk_cnt++; if ({lsu_icb_cmd_valid, agu_icb_cmd_ready} !== 2'b10) $display("[TB] FAIL lock_c0: got %b expected 10", {lsu_icb_cmd_valid, agu_icb_cmd_ready}); else pass_cnt++;
    tick();
    nice_icb_cmd_valid = 1'b1; nice_icb_cmd_addr = 32'h0000_0B20;
    #2;
    chk_cnt++; if (lsu_icb_cmd_addr !== 32'h0000_0A10) $display("[TB] FAIL lock_c1_addr: got %h expected 00000a10", lsu_icb_cmd_addr); else pass_cnt++;
    tick();
    nice_mem_holdup = 1'b1;
    #2;
    chk_cnt++; if ({lsu_icb_cmd_valid, lsu_icb_cmd_addr} !== {1'b1, 32'h0000_0A10}) $display("[TB] FAIL lock_c2_holdup: got %b/%h expected 1/00000a10", lsu_icb_cmd_valid, lsu_icb_cmd_addr); else pass_cnt++;
    tick();
    lsu_icb_cmd_ready = 1'b1;
    #2;
    chk_cnt++; if ({agu_icb_cmd_ready, nice_icb_cmd_ready} !== 2'b10) $display("[TB] FAIL lock_c3_hs: got %b expected 10", {agu_icb_cmd_ready, nice_icb_cmd_ready}); else pass_cnt++;
    tick();
    agu_icb_cmd_valid = 1'b0; nice_mem_holdup = 1'b0;
    #2;
    chk_cnt++; if ({nice_icb_cmd_ready, lsu_icb_cmd_addr} !== {1'b1, 32'h0000_0B20}) $display("[TB] FAIL lock_nice_after: got %b/%h expected 1/00000b20", nice_icb_cmd_ready, lsu_icb_cmd_addr); else pass_cnt++;
    tick();
    nice_icb_cmd_valid = 1'b0; lsu_icb_cmd_ready = 1'b0;
    lsu_icb_rsp_valid = 1'b1; agu_icb_rsp_ready = 1'b1; nice_icb_rsp_ready = 1'b1;
    #2;
    chk_cnt++; if ({agu_icb_rsp_valid, nice_icb_rsp_valid} !== 2'b10) $display("[TB] FAIL lock_rsp0: got %b expected 10", {agu_icb_rsp_valid, nice_icb_rsp_valid}); else pass_cnt++;
    tick();
    #2;
    chk_cnt++; if ({agu_icb_rsp_valid, nice_icb_rsp_valid} !== 2'b01) $display("[TB] FAIL lock_rsp1: got %b expected 01", {agu_icb_rsp_valid, nice_icb_rsp_valid}); else pass_cnt++;
    tick();
    drive_idle();
  endtask

  task automatic test_holdup();
    tick();
    nice_mem_holdup = 1'b1; agu_icb_cmd_valid = 1'b1; lsu_icb_cmd_ready = 1'b1;
    #2;
    chk_cnt++; if ({agu_icb_cmd_ready, lsu_icb_cmd_valid, arbt_active} !== 3'b001) $display("[TB] FAIL holdup_blk0: got %b expected 001", {agu_icb_cmd_ready, lsu_icb_cmd_valid, arbt_active}); else pass_cnt++;
    tick();
    #2;
    chk_cnt++; if ({agu_icb_cmd_ready, lsu_icb_cmd_valid} !== 2'b00) $display("[TB] FAIL holdup_blk1: got %b expected 00", {agu_icb_cmd_ready, lsu_icb_cmd_valid}); else pass_cnt++;
    tick();
    nice_mem_holdup = 1'b0;
    #2;
    chk_cnt++; if ({agu_icb_cmd_ready, lsu_icb_cmd_valid} !== 2'b11) $display("[TB] FAIL holdup_release: got %b expected 11", {agu_icb_cmd_ready, lsu_icb_cmd_valid}); else pass_cnt++;
    tick();
    agu_icb_cmd_valid = 1'b0; lsu_icb_cmd_ready = 1'b0; lsu_icb_rsp_valid = 1'b1; agu_icb_rsp_ready = 1'b1;
    #2;
    chk_cnt++; if (agu_icb_rsp_valid !== 1'b1) $display("[TB] FAIL holdup_rsp: got %b expected 1", agu_icb_rsp_valid); else pass_cnt++;
    tick();
    drive_idle();
    #2;
    chk_cnt++; if (arbt_active !== 1'b0) $display("[TB] FAIL holdup_drained: got %b expected 0", arbt_active); else pass_cnt++;
  endtask

  task automatic test_full();
    tick();
    agu_icb_cmd_valid = 1'b1; lsu_icb_cmd_ready = 1'b1;
    #2;
    chk_cnt++; if (agu_icb_cmd_ready !== 1'b1) $display("[TB] FAIL full_c0: got %b expected 1", agu_icb_cmd_ready); else pass_cnt++;
    tick();
    #2;
    chk_cnt++; if (agu_icb_cmd_ready !== 1'b1) $display("[TB] FAIL full_c1: got %b expected 1", agu_icb_cmd_ready); else pass_cnt++;
    tick();
    lsu_icb_rsp_valid = 1'b1; agu_icb_rsp_ready = 1'b1;
    #2;
    chk_cnt++; if ({agu_icb_cmd_ready, lsu_icb_cmd_valid, agu_icb_rsp_valid} !== 3'b001) $display("[TB] FAIL full_no_bypass: got %b expected 001", {agu_icb_cmd_ready, lsu_icb_cmd_valid, agu_icb_rsp_valid}); else pass_cnt++;
    tick();
    lsu_icb_rsp_valid = 1'b0;
    #2;
    chk_cnt++; if ({agu_icb_cmd_ready, lsu_icb_cmd_valid} !== 2'b11) $display("[TB] FAIL full_accept_next: got %b expected 11", {agu_icb_cmd_ready, lsu_icb_cmd_valid}); else pass_cnt++;
    tick();
    agu_icb_cmd_valid = 1'b0; lsu_icb_cmd_ready = 1'b0; lsu_icb_rsp_valid = 1'b1;
    tick();
    tick();
    drive_idle();
    #2;
    chk_cnt++; if (arbt_active !== 1'b0) $display("[TB] FAIL full_drained: got %b expected 0", arbt_active); else pass_cnt++;
  endtask

  task automatic test_orphan();
    tick();
    lsu_icb_rsp_valid = 1'b1;
    #2;
    chk_cnt++; if ({lsu_icb_rsp_ready, agu_icb_rsp_valid, nice_icb_rsp_valid, rsp_orphan_err} !== 4'b1000) $display("[TB] FAIL orphan_drain: got %b expected 1000", {lsu_icb_rsp_ready, agu_icb_rsp_valid, nice_icb_rsp_valid, rsp_orphan_err}); else pass_cnt++;
    tick();
    lsu_icb_rsp_valid = 1'b0;
    #2;
    chk_cnt++; if (rsp_orphan_err !== 1'b1) $display("[TB] FAIL orphan_set: got %b expected 1", rsp_orphan_err); else pass_cnt++;
    tick();
    tick();
    #2;
    chk_cnt++; if (rsp_orphan_err !== 1'b1) $display("[TB] FAIL orphan_sticky: got %b expected 1", rsp_orphan_err); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    tick();
    agu_icb_cmd_valid = 1'b1; lsu_icb_cmd_ready = 1'b1;
    tick();
    tick();
    agu_icb_cmd_valid = 1'b0; lsu_icb_cmd_ready = 1'b0;
    #2;
    chk_cnt++; if (arbt_active !== 1'b1) $display("[TB] FAIL rstmid_pending: got %b expected 1", arbt_active); else pass_cnt++;
    rst = 1'b1;
    #2;
    chk_cnt++; if ({arbt_active, lsu_icb_rsp_ready, rsp_orphan_err} !== 3'b000) $display("[TB] FAIL rstmid_during: got %b expected 000", {arbt_active, lsu_icb_rsp_ready, rsp_orphan_err}); else pass_cnt++;
    tick();
    rst = 1'b0;
    #2;
    chk_cnt++; if ({arbt_active, rsp_orphan_err} !== 2'b00) $display("[TB] FAIL rstmid_after: got %b expected 00", {arbt_active, rsp_orphan_err}); else pass_cnt++;
    tick();
    agu_icb_cmd_valid = 1'b1; lsu_icb_cmd_ready = 1'b1;
    #2;
    chk_cnt++; if (agu_icb_cmd_ready !== 1'b1) $display("[TB] FAIL rstmid_new_cmd: got %b expected 1", agu_icb_cmd_ready); else pass_cnt++;
    tick();
    agu_icb_cmd_valid = 1'b0; lsu_icb_cmd_ready = 1'b0; lsu_icb_rsp_valid = 1'b1; agu_icb_rsp_ready = 1'b1;
    tick();
    lsu_icb_rsp_valid = 1'b0;
    #2;
    chk_cnt++; if ({arbt_active, rsp_orphan_err} !== 2'b00) $display("[TB] FAIL rstmid_one_entry: got %b expected 00", {arbt_active, rsp_orphan_err}); else pass_cnt++;
    drive_idle();
  endtask

  // Model: owner queue of outstanding commands plus the requester a stalled
  // command is committed to (-1 when free to arbitrate).
  task automatic test_random(input int n);
    int q[$];
    int lock_src, gsrc;
    bit gval, full, orph, e_cv, e_rr, e_arv, e_nrv, cmd_hs, rsp_hs;
    logic [7:0] got_v, exp_v;
    logic [AW+DW+DW/8+2:0] got_p, exp_p;
    tick();
    drive_idle();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    q.delete();
    lock_src = -1;
    orph = 1'b0;
    for (int i = 0; i < n; i++) begin
      tick();
      nice_mem_holdup    = ($urandom_range(0, 3) == 0);
      agu_icb_cmd_valid  = $urandom_range(0, 1) == 1;
      nice_icb_cmd_valid = ($urandom_range(0, 2) == 0);
      lsu_icb_cmd_ready  = ($urandom_range(0, 3) != 0);
      lsu_icb_rsp_valid  = $urandom_range(0, 1) == 1;
      agu_icb_rsp_ready  = ($urandom_range(0, 3) != 0);
      nice_icb_rsp_ready = ($urandom_range(0, 3) != 0);
      agu_icb_cmd_addr = $urandom; agu_icb_cmd_wdata = $urandom; agu_icb_cmd_wmask = 4'($urandom); agu_icb_cmd_size = 2'($urandom); agu_icb_cmd_read = 1'($urandom);
      nice_icb_cmd_addr = $urandom; nice_icb_cmd_wdata = $urandom; nice_icb_cmd_wmask = 4'($urandom); nice_icb_cmd_size = 2'($urandom); nice_icb_cmd_read = 1'($urandom);
      lsu_icb_rsp_rdata = $urandom; lsu_icb_rsp_err = 1'($urandom);
      #2;
      if (lock_src >= 0) begin
        gsrc = lock_src;
        gval = (gsrc == 1) ? nice_icb_cmd_valid : agu_icb_cmd_valid;
      end else if (nice_icb_cmd_valid) begin
        gsrc = 1; gval = 1'b1;
      end else if (agu_icb_cmd_valid && !nice_mem_holdup) begin
        gsrc = 0; gval = 1'b1;
      end else begin
        gsrc = -1; gval = 1'b0;
      end
      full  = (q.size() == DEPTH);
      e_cv  = gval && !full;
      e_rr  = (q.size() == 0) ? 1'b1 : ((q[0] == 1) ? nice_icb_rsp_ready : agu_icb_rsp_ready);
      e_arv = lsu_icb_rsp_valid && q.size() > 0 && q[0] == 0;
      e_nrv = lsu_icb_rsp_valid && q.size() > 0 && q[0] == 1;
      exp_v = {e_cv, (gsrc == 0) && lsu_icb_cmd_ready && !full, (gsrc == 1) && lsu_icb_cmd_ready && !full,
               e_rr, e_arv, e_nrv, agu_icb_cmd_valid || nice_icb_cmd_valid || q.size() != 0, orph};
      got_v = {lsu_icb_cmd_valid, agu_icb_cmd_ready, nice_icb_cmd_ready, lsu_icb_rsp_ready,
               agu_icb_rsp_valid, nice_icb_rsp_valid, arbt_active, rsp_orphan_err};
      chk_cnt++; if (got_v !== exp_v) $display("[TB] FAIL rand_ctrl cycle %0d: got %b expected %b", i, got_v, exp_v); else pass_cnt++;
      if (e_cv) begin
        exp_p = (gsrc == 1) ? {nice_icb_cmd_addr, nice_icb_cmd_read, nice_icb_cmd_wdata, nice_icb_cmd_wmask, nice_icb_cmd_size}
                            : {agu_icb_cmd_addr, agu_icb_cmd_read, agu_icb_cmd_wdata, agu_icb_cmd_wmask, agu_icb_cmd_size};
        got_p = {lsu_icb_cmd_addr, lsu_icb_cmd_read, lsu_icb_cmd_wdata, lsu_icb_cmd_wmask, lsu_icb_cmd_size};
        chk_cnt++; if (got_p !== exp_p) $display("[TB] FAIL rand_payload cycle %0d: got %h expected %h", i, got_p, exp_p); else pass_cnt++;
      end
      if (e_arv || e_nrv) begin
        chk_cnt++;
        if ((e_arv ? {agu_icb_rsp_err, agu_icb_rsp_rdata} : {nice_icb_rsp_err, nice_icb_rsp_rdata}) !== {lsu_icb_rsp_err, lsu_icb_rsp_rdata})
          $display("[TB] FAIL rand_rsp_data cycle %0d: got %h expected %h", i,
                   e_arv ? {agu_icb_rsp_err, agu_icb_rsp_rdata} : {nice_icb_rsp_err, nice_icb_rsp_rdata}, {lsu_icb_rsp_err, lsu_icb_rsp_rdata});
        else pass_cnt++;
      end
      cmd_hs = e_cv && lsu_icb_cmd_ready;
      rsp_hs = lsu_icb_rsp_valid && e_rr && q.size() > 0;
      if (lsu_icb_rsp_valid && q.size() == 0) orph = 1'b1;
      if (cmd_hs) lock_src = -1;
      else if (e_cv) lock_src = gsrc;
      if (rsp_hs) void'(q.pop_front());
      if (cmd_hs) q.push_back(gsrc);
    end
    tick();
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_priority();
    test_lock();
    test_holdup();
    test_full();
    test_orphan();
    test_reset_mid();
    test_random(600);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
